// File: rtl/johnson_seq_pkg.sv
// Shared types and constants for the Johnson LED sequencer.
package johnson_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int SPEED_W = 2;

endpackage

// File: rtl/step_prescaler.sv
// Step prescaler: counts 0..term while advancing, holds otherwise, clear has priority.
module step_prescaler #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson LED sequencer with start/pause, direction and speed keys.
// Optional auto-stop after AUTO_CYCLES full cycles when JOHNSON_SEQ_AUTOSTOP_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | stopped, led forced to zero, prescaler held at zero
// ST_RUN   | prescaler running, led shifts on every terminal count
// ST_PAUSE | led and prescaler frozen until next start press
module johnson_seq_ctrl
  import johnson_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STEP_BASE   = 25_000_000,
  parameter int AUTO_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_start,
  input  logic               key_dir,
  input  logic               key_speed,
  output logic [WIDTH-1:0]   led,
  output logic [1:0]         state,
  output logic               dir,
  output logic [SPEED_W-1:0] speed,
  output logic               step
);

  localparam int CNT_W = $clog2(STEP_BASE);

  if (WIDTH < 2) begin : g_bad_width
    $error("johnson_seq_ctrl: WIDTH must be at least 2");
  end
  if (STEP_BASE < 8) begin : g_bad_base
    $error("johnson_seq_ctrl: STEP_BASE must be at least 8");
  end
  if (AUTO_CYCLES < 1) begin : g_bad_auto
    $error("johnson_seq_ctrl: AUTO_CYCLES must be at least 1");
  end

  state_t           state_q;
  logic [CNT_W-1:0] term;
  logic             tc;
  logic             in_run;
  logic [WIDTH-1:0] next_led;

  assign state  = state_q;
  assign in_run = (state_q == ST_RUN);
  // A start press on the terminal count pauses instead of stepping.
  assign step   = in_run && tc && !key_start;

  always_comb begin
    term = CNT_W'((STEP_BASE >> speed) - 1);
  end

  always_comb begin
    next_led = led;
    if (!dir) next_led = {led[WIDTH-2:0], ~led[WIDTH-1]};
    else      next_led = {~led[0], led[WIDTH-1:1]};
  end

  // The press cycle itself does not advance, so a resume continues from the held count.
  step_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clear   (key_speed || (state_q == ST_IDLE)),
    .advance (in_run && !key_start),
    .term    (term),
    .tc      (tc)
  );

`ifdef JOHNSON_SEQ_AUTOSTOP_EN
  localparam int CYC_W = $clog2(AUTO_CYCLES + 1);
  logic [CYC_W-1:0] cyc_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led     <= '0;
      dir     <= 1'b0;
      speed   <= '0;
`ifdef JOHNSON_SEQ_AUTOSTOP_EN
      cyc_cnt <= '0;
`endif
    end else begin
      if (key_dir)   dir   <= ~dir;
      if (key_speed) speed <= speed + 1'b1;
      if (step)      led   <= next_led;

      case (state_q)
        ST_IDLE:  if (key_start) state_q <= ST_RUN;
        ST_RUN:   if (key_start) state_q <= ST_PAUSE;
        ST_PAUSE: if (key_start) state_q <= ST_RUN;
        default:  state_q <= ST_IDLE;
      endcase

`ifdef JOHNSON_SEQ_AUTOSTOP_EN
      if (state_q == ST_IDLE) begin
        cyc_cnt <= '0;
      end else if (step && (next_led == '0)) begin
        if (cyc_cnt == CYC_W'(AUTO_CYCLES - 1)) begin
          state_q <= ST_IDLE;
          cyc_cnt <= '0;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl (WIDTH=4, STEP_BASE=8).
module tb_johnson_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_start = 1'b0;
  logic       key_dir = 1'b0;
  logic       key_speed = 1'b0;
  logic [3:0] led;
  logic [1:0] state;
  logic       dir;
  logic [1:0] speed;
  logic       step;

  int checks = 0;
  int failures = 0;

  johnson_seq_ctrl #(
    .WIDTH       (4),
    .STEP_BASE   (8),
    .AUTO_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_start (key_start),
    .key_dir   (key_dir),
    .key_speed (key_speed),
    .led       (led),
    .state     (state),
    .dir       (dir),
    .speed     (speed),
    .step      (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until step is high (bounded); n = cycles waited.
  task automatic wait_step(input string tag, output int n);
    n = 0;
    while (step !== 1'b1 && n < 64) begin
      cyc(1);
      n++;
    end
    chk({tag, "_seen"}, 32'(step), 32'(1'b1));
  endtask

  initial begin
    logic [3:0] left_seq [8];
    logic [3:0] right_seq [4];
    logic       step_seen;
    int         n;

    left_seq  = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    right_seq = '{4'b1100, 4'b1110, 4'b1111, 4'b0111};

    // Reset values
    cyc(2);
    chk("rst_led",   32'(led),   32'(4'b0000));
    chk("rst_state", 32'(state), 32'(2'd0));
    chk("rst_dir",   32'(dir),   32'(1'b0));
    chk("rst_speed", 32'(speed), 32'(2'd0));
    chk("rst_step",  32'(step),  32'(1'b0));
    rst = 1'b0;

    // Idle for 50 cycles
    step_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      step_seen |= step;
    end
    chk("idle_step",  32'(step_seen), 32'(1'b0));
    chk("idle_led",   32'(led),       32'(4'b0000));
    chk("idle_state", 32'(state),     32'(2'd0));

    // Start: RUN next cycle, first step P-1 cycles later
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    chk("start_state", 32'(state), 32'(2'd1));
    wait_step("first_step", n);
    chk("first_latency", 32'(n), 32'(7));
    chk("first_led_hold", 32'(led), 32'(4'b0000));
    cyc(1);
    chk("first_led", 32'(led), 32'(4'b0001));

    // Full left Johnson cycle, every 8 cycles
    for (int i = 0; i < 8; i++) begin
      wait_step("left_step", n);
      chk("left_period", 32'(n), 32'(7));
      cyc(1);
      chk("left_led", 32'(led), 32'(left_seq[i]));
    end

    // Advance to 0111, pause at prescaler count 3
    for (int i = 0; i < 2; i++) begin
      wait_step("to_0111", n);
      cyc(1);
    end
    chk("pre_pause_led", 32'(led), 32'(4'b0111));
    cyc(3);
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    chk("pause_state", 32'(state), 32'(2'd2));
    step_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      step_seen |= step;
    end
    chk("pause_led",  32'(led),       32'(4'b0111));
    chk("pause_step", 32'(step_seen), 32'(1'b0));

    // Resume: remaining count is 3..7
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    chk("resume_state", 32'(state), 32'(2'd1));
    wait_step("resume_step", n);
    chk("resume_latency", 32'(n), 32'(4));
    cyc(1);
    chk("resume_led", 32'(led), 32'(4'b1111));

    // Continue left to 0011
    for (int i = 0; i < 6; i++) begin
      wait_step("to_0011", n);
      cyc(1);
    end
    chk("pre_dir_led", 32'(led), 32'(4'b0011));

    // Direction toggle: right shift 0001, 0000, 1000
    key_dir = 1'b1;
    cyc(1);
    key_dir = 1'b0;
    chk("dir_right", 32'(dir), 32'(1'b1));
    wait_step("dir_step0", n);
    cyc(1);
    chk("dir_led0", 32'(led), 32'(4'b0001));
    wait_step("dir_step1", n);
    cyc(1);
    chk("dir_led1", 32'(led), 32'(4'b0000));
    wait_step("dir_step2", n);
    cyc(1);
    chk("dir_led2", 32'(led), 32'(4'b1000));

    // Three speed presses: speed 3, step every cycle
    for (int i = 0; i < 3; i++) begin
      key_speed = 1'b1;
      cyc(1);
    end
    key_speed = 1'b0;
    chk("speed3", 32'(speed), 32'(2'd3));
    chk("speed3_led_hold", 32'(led), 32'(4'b1000));
    for (int i = 0; i < 4; i++) begin
      chk("fast_step", 32'(step), 32'(1'b1));
      cyc(1);
      chk("fast_led", 32'(led), 32'(right_seq[i]));
    end

    // Fourth press coincides with a step: step taken, speed wraps, prescaler cleared
    chk("wrap_step", 32'(step), 32'(1'b1));
    key_speed = 1'b1;
    cyc(1);
    key_speed = 1'b0;
    chk("speed_wrap", 32'(speed), 32'(2'd0));
    chk("wrap_led",   32'(led),   32'(4'b0011));
    wait_step("slow_step", n);
    chk("slow_period", 32'(n), 32'(7));
    cyc(1);
    chk("slow_led", 32'(led), 32'(4'b0001));

    // key_start coinciding with terminal count: pause wins, no step
    wait_step("coinc_wait", n);
    key_start = 1'b1;
    #1;
    chk("coinc_step", 32'(step), 32'(1'b0));
    cyc(1);
    key_start = 1'b0;
    chk("coinc_state", 32'(state), 32'(2'd2));
    cyc(1);
    chk("coinc_led", 32'(led), 32'(4'b0001));

    // Resume with held terminal count: step immediately
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    #1;
    chk("coinc_resume_step", 32'(step), 32'(1'b1));
    cyc(1);
    chk("coinc_resume_led", 32'(led), 32'(4'b0000));
    wait_step("pre_reset_step", n);
    cyc(1);
    chk("pre_reset_led", 32'(led), 32'(4'b1000));

    // Asynchronous reset mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("async_led",   32'(led),   32'(4'b0000));
    chk("async_state", 32'(state), 32'(2'd0));
    chk("async_dir",   32'(dir),   32'(1'b0));
    chk("async_step",  32'(step),  32'(1'b0));
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Uninterrupted run of 24 steps from reset
    key_start = 1'b1;
    cyc(1);
    key_start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      wait_step("long_step", n);
      cyc(1);
    end
    chk("long_led", 32'(led), 32'(4'b0000));
`ifdef JOHNSON_SEQ_AUTOSTOP_EN
    chk("autostop_state", 32'(state), 32'(2'd0));
    step_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      step_seen |= step;
    end
    chk("autostop_step", 32'(step_seen), 32'(1'b0));
    chk("autostop_led",  32'(led),       32'(4'b0000));
`else
    chk("norun_stop_state", 32'(state), 32'(2'd1));
    wait_step("continue_step", n);
    chk("continue_period", 32'(n), 32'(7));
    cyc(1);
    chk("continue_led", 32'(led), 32'(4'b0001));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Controller that sequences a Johnson-counter LED pattern from debounced key-press pulses. It sits after the per-key debounce stage and replaces the fixed free-running Johnson counter with a start/pause/direction/speed-controlled one. A run/pause FSM and a programmable step prescaler decide when the shift register advances.

## Interface
- `WIDTH`, 4: number of LED outputs; Johnson period is 2×WIDTH steps; must be ≥2.
- `STEP_BASE`, 25_000_000: clocks per step at speed 0 (0.5 s at 50 MHz); must be ≥8.
- `AUTO_CYCLES`, 3: full Johnson cycles before auto-stop; used only with `JOHNSON_SEQ_AUTOSTOP_EN`.

- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `key_start` in 1: one-cycle press pulse; start/pause toggle.
- `key_dir` in 1: one-cycle press pulse; toggles shift direction.
- `key_speed` in 1: one-cycle press pulse; advances speed level.
- `led` out WIDTH: Johnson pattern.
- `state` out 2: 0=IDLE, 1=RUN, 2=PAUSE.
- `dir` out 1: 0=left (toward MSB), 1=right.
- `speed` out 2: speed level 0..3.
- `step` out 1: high in the cycle before `led` advances.

## Operation
- Reset values: `led`=0, `state`=IDLE, `dir`=0, `speed`=0, `step`=0, prescaler count=0, cycle count=0.
- FSM on `key_start`: IDLE→RUN (prescaler cleared); RUN→PAUSE; PAUSE→RUN (prescaler resumes from its held value). No other transitions except reset and auto-stop.
- IDLE: `led` held at 0, prescaler held at 0.
- PAUSE: `led` and prescaler held.
- Step period P = STEP_BASE >> `speed` (speed 0..3 gives divide by 1, 2, 4, 8). Prescaler counts 0..P-1 in RUN and wraps.
- `step` = (state==RUN) && (cnt==P-1) && !`key_start`. Combinational from registered state.
- On step, left shift: `led` ← {led[WIDTH-2:0], ~led[WIDTH-1]}. Right shift: `led` ← {~led[0], led[WIDTH-1:1]}.
- `key_dir` toggles `dir` in any state. The new direction applies from the next step onward.
- `key_speed` increments `speed` modulo 4 (3→0) in any state and clears the prescaler.
- Simultaneous events: each key is processed independently in the same cycle. If `key_start` and the terminal count coincide in RUN, the transition to PAUSE wins and no step occurs. If `key_speed` and the terminal count coincide, the step occurs and the prescaler is cleared.
- Prescaler width is $clog2(STEP_BASE). Compare against P-1 computed at that width.

## Timing
- `key_start` asserted in cycle N while IDLE → `state`=RUN in N+1 → `step` high in cycle N+P → new `led` visible in N+P+1.
- Subsequent steps occur every P cycles while in RUN.
- Key effects on `dir`, `speed` and `state` are visible one cycle after the pulse.
- Reset asserted mid-run returns all outputs to reset values immediately (asynchronously). Release is synchronous to `clk`.

## Configuration
- `JOHNSON_SEQ_AUTOSTOP_EN` defined:
  - A cycle counter increments on each step that returns `led` to all-zero.
  - When the counter reaches AUTO_CYCLES, the same edge forces `state`=IDLE and clears the counter.
  - The counter is also cleared on any entry to IDLE.
- Not defined: no cycle counter is built, and RUN continues until `key_start` or reset.

## Structure
- Package `johnson_seq_pkg`: state encodings (IDLE, RUN, PAUSE) and speed width constant (2).
- Sub-module `step_prescaler`: counter with hold, clear and programmable terminal count; outputs the terminal-count flag.
- The FSM, shift register and optional cycle counter live in the top module.

## Test plan
Run all scenarios with WIDTH=4, STEP_BASE=8.
- Reset then idle 50 cycles → `led`=0000, `state`=0, `step` never high.
- `key_start` once → `led` advances every 8 cycles through 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
- Run to 0111, then `key_start` → `state`=2, `led` holds for 40 cycles. Second `key_start` → resumes; the next step arrives after the remaining prescaler count.
- At 0011, pulse `key_dir` → next steps give 0001, 0000, 1000, matching right-shift behaviour.
- Pulse `key_speed` three times → speed=3, step every 1 cycle. Fourth pulse → speed=0, step period 8.
- `key_start` coinciding with `step` cycle → PAUSE, `led` unchanged. With the macro defined and AUTO_CYCLES=3, an uninterrupted run returns to IDLE after 24 steps with `led`=0000.
